// File: rtl/ft_tx_sched.sv
// FT245 synchronous-FIFO transmit scheduler: buffers FFT bins and serialises each
// into an 8-byte packet with a 0xF sync nibble, honouring TXE# backpressure and suspend.
module ft_tx_sched #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter bit          FLUSH_EN   = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          word_valid_i,
    input  logic [IDX_WIDTH-1:0]          idx_i,
    input  logic [DATA_WIDTH-1:0]         re_i,
    input  logic [DATA_WIDTH-1:0]         im_i,
    input  logic                          ft_txe_n_i,
    input  logic                          ft_suspend_n_i,
    output logic [7:0]                    ft_data_o,
    output logic                          ft_data_oe_o,
    output logic                          ft_wr_n_o,
    output logic                          ft_siwua_n_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   pkt_ctr_o
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W     = AW + 1;
    localparam int unsigned WORD_W    = IDX_WIDTH + 2 * DATA_WIDTH;
    localparam int unsigned PKT_W     = WORD_W + 4;
    localparam int unsigned NBYTES    = PKT_W / 8;
    localparam int unsigned BCNT_W    = $clog2(NBYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_FLUSH
    } state_e;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;

    state_e            state_q;
    logic [PKT_W-1:0]  sreg_q;
    logic [BCNT_W-1:0] byte_q;
    logic              last_q;
    logic [7:0]        data_q;
    logic              wr_n_q;
    logic              oe_q;
    logic              siwua_n_q;
    logic [15:0]       pkt_ctr_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              accept;
    logic [WORD_W-1:0] head_word;
    logic [PKT_W-1:0]  pkt_word;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop        = (state_q == S_LOAD);
    // A full FIFO still takes a word when the same edge pops one.
    assign push       = word_valid_i && (!fifo_full || pop);
    assign head_word  = mem_q[rd_ptr_q];
    assign pkt_word   = {4'hF, head_word};
    assign accept     = !wr_n_q && !ft_txe_n_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {idx_i, re_i, im_i};
        end
    end

    // FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (word_valid_i && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Packet FSM; bus outputs are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            data_q    <= 8'h00;
            wr_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            siwua_n_q <= 1'b1;
            pkt_ctr_q <= 16'h0000;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    wr_n_q    <= 1'b1;
                    oe_q      <= 1'b0;
                    siwua_n_q <= 1'b1;
                    if (!fifo_empty && en_i && ft_suspend_n_i) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sreg_q  <= pkt_word;
                    data_q  <= pkt_word[PKT_W-1 -: 8];
                    byte_q  <= '0;
                    last_q  <= (head_word[WORD_W-1 -: IDX_WIDTH] == LAST_IDX);
                    wr_n_q  <= !ft_suspend_n_i;
                    oe_q    <= ft_suspend_n_i;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (accept && (byte_q == LAST_BYTE)) begin
                        pkt_ctr_q <= pkt_ctr_q + 16'd1;
                        wr_n_q    <= 1'b1;
                        oe_q      <= 1'b0;
                        if (last_q && FLUSH_EN) begin
                            siwua_n_q <= 1'b0;
                            state_q   <= S_FLUSH;
                        end else if (!fifo_empty && en_i) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        // Suspend drops the strobe but keeps the byte for re-presentation.
                        if (accept) begin
                            sreg_q <= {sreg_q[PKT_W-9:0], 8'h00};
                            data_q <= sreg_q[PKT_W-9 -: 8];
                            byte_q <= byte_q + BCNT_W'(1);
                        end
                        wr_n_q <= !ft_suspend_n_i;
                        oe_q   <= ft_suspend_n_i;
                    end
                end
                S_FLUSH: begin
                    siwua_n_q <= 1'b1;
                    wr_n_q    <= 1'b1;
                    oe_q      <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ft_data_o    = data_q;
    assign ft_data_oe_o = oe_q;
    assign ft_wr_n_o    = wr_n_q;
    assign ft_siwua_n_o = siwua_n_q;
    assign overflow_o   = overflow_q;
    assign fifo_level_o = level_q;
    assign pkt_ctr_o    = pkt_ctr_q;

endmodule

// File: tb/tb_ft_tx_sched.sv
// Bench for ft_tx_sched: directed scenarios plus randomized traffic checked against
// a packet-queue model of the byte stream seen on the FT bus.
module tb_ft_tx_sched;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 10;
    localparam int unsigned DW    = 25;

    logic           clk_i;
    logic           rst_n;
    logic           en_i;
    logic           word_valid_i;
    logic [IW-1:0]  idx_i;
    logic [DW-1:0]  re_i;
    logic [DW-1:0]  im_i;
    logic           ft_txe_n_i;
    logic           ft_suspend_n_i;
    logic [7:0]     ft_data_o;
    logic           ft_data_oe_o;
    logic           ft_wr_n_o;
    logic           ft_siwua_n_o;
    logic           overflow_o;
    logic [4:0]     fifo_level_o;
    logic [15:0]    pkt_ctr_o;

    logic [7:0]     nf_data;
    logic           nf_oe;
    logic           nf_wr_n;
    logic           nf_siwua_n;
    logic           nf_ovf;
    logic [4:0]     nf_level;
    logic [15:0]    nf_pkt;

    ft_tx_sched #(.FIFO_DEPTH(DEPTH), .IDX_WIDTH(IW), .DATA_WIDTH(DW),
                  .FRAME_LEN(1024), .FLUSH_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .word_valid_i(word_valid_i),
        .idx_i(idx_i), .re_i(re_i), .im_i(im_i),
        .ft_txe_n_i(ft_txe_n_i), .ft_suspend_n_i(ft_suspend_n_i),
        .ft_data_o(ft_data_o), .ft_data_oe_o(ft_data_oe_o), .ft_wr_n_o(ft_wr_n_o),
        .ft_siwua_n_o(ft_siwua_n_o), .overflow_o(overflow_o),
        .fifo_level_o(fifo_level_o), .pkt_ctr_o(pkt_ctr_o)
    );

    ft_tx_sched #(.FIFO_DEPTH(DEPTH), .IDX_WIDTH(IW), .DATA_WIDTH(DW),
                  .FRAME_LEN(1024), .FLUSH_EN(1'b0)) dut_nf (
        .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .word_valid_i(word_valid_i),
        .idx_i(idx_i), .re_i(re_i), .im_i(im_i),
        .ft_txe_n_i(ft_txe_n_i), .ft_suspend_n_i(ft_suspend_n_i),
        .ft_data_o(nf_data), .ft_data_oe_o(nf_oe), .ft_wr_n_o(nf_wr_n),
        .ft_siwua_n_o(nf_siwua_n), .overflow_o(nf_ovf),
        .fifo_level_o(nf_level), .pkt_ctr_o(nf_pkt)
    );

    initial begin
        clk_i = 1'b0;
        forever #8 clk_i = ~clk_i;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [63:0] exp_q[$];
    int          mon_nbytes = 0;
    int          cyc = 0;
    int          last_b0 = 0;
    int          prev_b0 = 0;
    int          wr_low = 0;
    int          mdl_pkts = 0;
    int          flush_seen = 0;
    int          flush_exp = 0;
    int          nf_flush = 0;
    bit          rand_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input logic [IW-1:0] idx,
                                            input logic [DW-1:0] re,
                                            input logic [DW-1:0] im);
        return {4'hF, idx, re, im};
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] w, input int n);
        return w[63-8*n -: 8];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [IW-1:0] idx, input logic [DW-1:0] re,
                             input logic [DW-1:0] im, input bit accepted);
        idx_i        = idx;
        re_i         = re;
        im_i         = im;
        word_valid_i = 1'b1;
        step();
        word_valid_i = 1'b0;
        if (accepted) exp_q.push_back(mk_word(idx, re, im));
    endtask

    task automatic push_rand(output logic [63:0] w);
        logic [IW-1:0] idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        idx = ($urandom_range(0, 7) == 0) ? IW'(1023) : IW'($urandom);
        re  = DW'($urandom);
        im  = DW'($urandom);
        w   = mk_word(idx, re, im);
        push_word(idx, re, im, 1'b1);
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (mon_nbytes != n && c < 200) begin
            step();
            c++;
        end
        check("wait_bytes_timeout", 64'(c >= 200), 64'(0));
    endtask

    task automatic wait_drained(input int budget);
        int c = 0;
        while (!(exp_q.size() == 0 && fifo_level_o == 5'd0 && ft_wr_n_o && ft_siwua_n_o)
               && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", 64'(c >= budget), 64'(0));
        repeat (2) step();
    endtask

    // Bus monitor: a byte is taken on every edge where WR# and TXE# are both low.
    initial begin
        logic [63:0] word;
        logic [63:0] exp_w;
        bit          chk_flush;
        bit          flush_want;
        word = '0;
        chk_flush = 1'b0;
        flush_want = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!ft_siwua_n_o) flush_seen++;
            if (!nf_siwua_n) nf_flush++;
            if (!ft_wr_n_o) wr_low++;
            check("oe_vs_wr_n", 64'(ft_data_oe_o), 64'(!ft_wr_n_o));
            if (!rst_n) begin
                mon_nbytes = 0;
                chk_flush  = 1'b0;
            end else begin
                if (chk_flush) begin
                    check("siwua_after_pkt", 64'(ft_siwua_n_o), 64'(!flush_want));
                    chk_flush = 1'b0;
                end
                if (!ft_wr_n_o && !ft_txe_n_i) begin
                    if (mon_nbytes == 0) begin
                        prev_b0 = last_b0;
                        last_b0 = cyc;
                    end
                    word = {word[55:0], ft_data_o};
                    mon_nbytes++;
                    if (mon_nbytes == 8) begin
                        mon_nbytes = 0;
                        check("pkt_expected", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            exp_w = exp_q.pop_front();
                            check("pkt_data", word, exp_w);
                            flush_want = (exp_w[59:50] == 10'd1023);
                            if (flush_want) flush_exp++;
                            chk_flush = 1'b1;
                            mdl_pkts++;
                        end
                    end
                end
            end
        end
    end

    // Random bus conditions, active only during the randomized phase.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_mode) begin
                ft_txe_n_i     = ($urandom_range(0, 9) < 3);
                ft_suspend_n_i = ($urandom_range(0, 19) != 0);
                en_i           = ($urandom_range(0, 9) != 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] w;
        logic [63:0] w2;
        int p0;
        int f0;
        rst_n = 1'b0; en_i = 1'b0; word_valid_i = 1'b0;
        idx_i = '0; re_i = '0; im_i = '0;
        ft_txe_n_i = 1'b1; ft_suspend_n_i = 1'b1;
        repeat (3) step();
        check("rst_wr_n", 64'(ft_wr_n_o), 64'(1));
        check("rst_siwua_n", 64'(ft_siwua_n_o), 64'(1));
        check("rst_data", 64'(ft_data_o), 64'(0));
        check("rst_oe", 64'(ft_data_oe_o), 64'(0));
        check("rst_overflow", 64'(overflow_o), 64'(0));
        check("rst_level", 64'(fifo_level_o), 64'(0));
        check("rst_pkt_ctr", 64'(pkt_ctr_o), 64'(0));
        rst_n = 1'b1; en_i = 1'b1; ft_txe_n_i = 1'b0;
        step();

        // Basic packet and latency
        wr_low = 0;
        w = mk_word(10'h155, 25'h0ABCDEF, 25'h1234567);
        push_word(10'h155, 25'h0ABCDEF, 25'h1234567, 1'b1);
        check("lat_level", 64'(fifo_level_o), 64'(1));
        step();
        check("lat_load_wr_n", 64'(ft_wr_n_o), 64'(1));
        step();
        check("lat_wr_n", 64'(ft_wr_n_o), 64'(0));
        check("lat_byte0", 64'(ft_data_o), 64'(byte_of(w, 0)));
        wait_drained(100);
        check("basic_wr_low", 64'(wr_low), 64'(8));
        check("basic_pkt_ctr", 64'(pkt_ctr_o), 64'(1));

        // Back-to-back throughput
        wr_low = 0;
        push_rand(w);
        push_rand(w2);
        wait_drained(100);
        check("tput_gap", 64'(last_b0 - prev_b0), 64'(9));
        check("tput_wr_low", 64'(wr_low), 64'(16));

        // Backpressure on byte3
        wr_low = 0;
        push_rand(w);
        wait_bytes(3);
        ft_txe_n_i = 1'b1;
        repeat (5) begin
            step();
            check("bp_hold_byte", 64'(ft_data_o), 64'(byte_of(w, 3)));
            check("bp_hold_wr_n", 64'(ft_wr_n_o), 64'(0));
        end
        ft_txe_n_i = 1'b0;
        wait_drained(100);
        check("bp_wr_low", 64'(wr_low), 64'(13));

        // Frame-end flush
        f0 = flush_seen;
        push_word(10'd1022, DW'($urandom), DW'($urandom), 1'b1);
        push_word(10'd1023, DW'($urandom), DW'($urandom), 1'b1);
        push_word(10'd0, DW'($urandom), DW'($urandom), 1'b1);
        wait_drained(100);
        check("flush_count", 64'(flush_seen - f0), 64'(1));

        // Suspend during byte5
        push_rand(w);
        wait_bytes(5);
        ft_txe_n_i = 1'b1;
        ft_suspend_n_i = 1'b0;
        step();
        check("susp_wr_n", 64'(ft_wr_n_o), 64'(1));
        repeat (3) step();
        check("susp_wr_n_hold", 64'(ft_wr_n_o), 64'(1));
        check("susp_data_hold", 64'(ft_data_o), 64'(byte_of(w, 5)));
        ft_suspend_n_i = 1'b1;
        ft_txe_n_i = 1'b0;
        step();
        check("resume_wr_n", 64'(ft_wr_n_o), 64'(0));
        check("resume_byte5", 64'(ft_data_o), 64'(byte_of(w, 5)));
        wait_drained(100);

        // Enable dropped mid-packet
        p0 = mdl_pkts;
        push_rand(w);
        push_rand(w2);
        wait_bytes(2);
        en_i = 1'b0;
        repeat (25) step();
        check("en_off_pkts", 64'(mdl_pkts - p0), 64'(1));
        check("en_off_level", 64'(fifo_level_o), 64'(1));
        check("en_off_wr_n", 64'(ft_wr_n_o), 64'(1));
        en_i = 1'b1;
        wait_drained(100);
        check("en_on_pkts", 64'(mdl_pkts - p0), 64'(2));

        // Overflow: 20 pushes into a stalled 16-deep FIFO
        en_i = 1'b0;
        ft_txe_n_i = 1'b1;
        p0 = mdl_pkts;
        for (int i = 0; i < 20; i++) begin
            push_word(IW'(i + 100), DW'($urandom), DW'($urandom), (i < 16));
        end
        check("ovf_level", 64'(fifo_level_o), 64'(16));
        check("ovf_flag", 64'(overflow_o), 64'(1));
        en_i = 1'b1;
        ft_txe_n_i = 1'b0;
        wait_drained(400);
        check("ovf_pkts", 64'(mdl_pkts - p0), 64'(16));
        check("ovf_sticky", 64'(overflow_o), 64'(1));
        check("pkt_ctr_pre_rst", 64'(pkt_ctr_o), 64'(16'(mdl_pkts)));

        // Reset at byte4
        push_rand(w);
        wait_bytes(4);
        ft_txe_n_i = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        check("midrst_wr_n", 64'(ft_wr_n_o), 64'(1));
        check("midrst_level", 64'(fifo_level_o), 64'(0));
        check("midrst_pkt_ctr", 64'(pkt_ctr_o), 64'(0));
        check("midrst_overflow", 64'(overflow_o), 64'(0));
        rst_n = 1'b1;
        ft_txe_n_i = 1'b0;
        mdl_pkts = 0;
        repeat (5) step();
        check("midrst_no_resume", 64'(ft_wr_n_o), 64'(1));

        // Randomized traffic
        rand_mode = 1'b1;
        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) push_rand(w);
            wait_drained(2000);
        end
        rand_mode = 1'b0;
        step();
        en_i = 1'b1; ft_txe_n_i = 1'b0; ft_suspend_n_i = 1'b1;
        wait_drained(200);

        check("final_pkt_ctr", 64'(pkt_ctr_o), 64'(16'(mdl_pkts)));
        check("final_flush_count", 64'(flush_seen), 64'(flush_exp));
        check("noflush_inst_siwua", 64'(nf_flush), 64'(0));
        check("final_overflow", 64'(overflow_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
